// File: rtl/bcd_scaler_mc_if.sv
// ============================================================================
// Module      : bcd_scaler_mc_if
// Description : Request/result bundle for the multi-channel BCD scaler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bcd_scaler_mc_if #(
    parameter int DATA_W     = 10,
    parameter int NUM_CH     = 3,
    parameter int NUM_DIGITS = 4
);
    logic                             Load;
    logic [NUM_CH*DATA_W-1:0]         data_in;
    logic [NUM_CH*4*NUM_DIGITS-1:0]   bcd_out;
    logic [NUM_CH-1:0]                negative;
    logic [NUM_CH-1:0]                overflow;
    logic                             busy;
    logic                             done;

    modport master (
        output Load, data_in,
        input  bcd_out, negative, overflow, busy, done
    );

    modport slave (
        input  Load, data_in,
        output bcd_out, negative, overflow, busy, done
    );
endinterface

`default_nettype wire

// File: rtl/bcd_scaler_mc.sv
// ============================================================================
// Module      : bcd_scaler_mc
// Description : Sequential signed-sample to BCD converter, one bit per cycle
//               per channel (double-dabble). BCD_SATURATE_EN clamps
//               overflowing channels to all nines.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_scaler_mc #(
    parameter int DATA_W      = 10,
    parameter int NUM_CH      = 3,
    parameter int NUM_DIGITS  = 4,
    parameter int SCALE_SHIFT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    bcd_scaler_mc_if.slave   bus
);
    localparam int W        = DATA_W + SCALE_SHIFT;
    localparam int CNT_W    = (W > 1) ? $clog2(W) : 1;
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CH_BCD_W = 4 * NUM_DIGITS;
    localparam logic [63:0] BCD_MAX = 64'(10 ** NUM_DIGITS) - 64'd1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_CH = 3'd1,
        SHIFT   = 3'd2,
        STORE   = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t                         state_q, state_d;
    logic [NUM_CH*DATA_W-1:0]       snap_q, snap_d;
    logic [CH_W-1:0]                ch_q, ch_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic [W-1:0]                   mag_q, mag_d;
    logic [CH_BCD_W-1:0]            acc_q, acc_d;
    logic [NUM_CH*CH_BCD_W-1:0]     work_bcd_q, work_bcd_d;
    logic [NUM_CH-1:0]              work_neg_q, work_neg_d;
    logic [NUM_CH-1:0]              work_ovf_q, work_ovf_d;
    logic [NUM_CH*CH_BCD_W-1:0]     bcd_out_q, bcd_out_d;
    logic [NUM_CH-1:0]              neg_out_q, neg_out_d;
    logic [NUM_CH-1:0]              ovf_out_q, ovf_out_d;
    logic                           done_q, done_d;

    logic [DATA_W-1:0]              w_sample;
    logic [DATA_W-1:0]              w_abs;
    logic [W-1:0]                   w_scaled;
    logic [CH_BCD_W-1:0]            w_adj;
    logic [CH_BCD_W-1:0]            w_shifted;
    logic [CH_BCD_W-1:0]            w_digits;
    logic                           w_ovf;

    // Unsigned negation keeps the most-negative sample as 2^(DATA_W-1).
    assign w_sample = snap_q[int'(ch_q)*DATA_W +: DATA_W];
    assign w_abs    = w_sample[DATA_W-1] ? -w_sample : w_sample;
    assign w_scaled = W'(w_abs) << SCALE_SHIFT;

    generate
        for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dabble
            assign w_adj[i*4 +: 4] = (acc_q[i*4 +: 4] >= 4'd5) ?
                                     acc_q[i*4 +: 4] + 4'd3 : acc_q[i*4 +: 4];
        end
    endgenerate

    assign w_shifted = {w_adj[CH_BCD_W-2:0], mag_q[cnt_q]};
    assign w_ovf     = 64'(mag_q) > BCD_MAX;

`ifdef BCD_SATURATE_EN
    assign w_digits = w_ovf ? {NUM_DIGITS{4'h9}} : acc_q;
`else
    assign w_digits = acc_q;
`endif

    always_comb begin
        state_d    = state_q;
        snap_d     = snap_q;
        ch_d       = ch_q;
        cnt_d      = cnt_q;
        mag_d      = mag_q;
        acc_d      = acc_q;
        work_bcd_d = work_bcd_q;
        work_neg_d = work_neg_q;
        work_ovf_d = work_ovf_q;
        bcd_out_d  = bcd_out_q;
        neg_out_d  = neg_out_q;
        ovf_out_d  = ovf_out_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.Load) begin
                    snap_d  = bus.data_in;
                    ch_d    = '0;
                    state_d = LOAD_CH;
                end
            end
            LOAD_CH: begin
                mag_d   = w_scaled;
                acc_d   = '0;
                cnt_d   = CNT_W'(W - 1);
                state_d = SHIFT;
            end
            SHIFT: begin
                acc_d = w_shifted;
                if (cnt_q == '0) begin
                    state_d = STORE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            STORE: begin
                work_bcd_d[int'(ch_q)*CH_BCD_W +: CH_BCD_W] = w_digits;
                work_neg_d[ch_q] = w_sample[DATA_W-1];
                work_ovf_d[ch_q] = w_ovf;
                if (ch_q == CH_W'(NUM_CH - 1)) begin
                    // Publish on the edge that enters DONE so results are valid with done.
                    bcd_out_d = work_bcd_d;
                    neg_out_d = work_neg_d;
                    ovf_out_d = work_ovf_d;
                    done_d    = 1'b1;
                    state_d   = DONE;
                end else begin
                    ch_d    = ch_q + CH_W'(1);
                    state_d = LOAD_CH;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            snap_q     <= '0;
            ch_q       <= '0;
            cnt_q      <= '0;
            mag_q      <= '0;
            acc_q      <= '0;
            work_bcd_q <= '0;
            work_neg_q <= '0;
            work_ovf_q <= '0;
            bcd_out_q  <= '0;
            neg_out_q  <= '0;
            ovf_out_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            snap_q     <= snap_d;
            ch_q       <= ch_d;
            cnt_q      <= cnt_d;
            mag_q      <= mag_d;
            acc_q      <= acc_d;
            work_bcd_q <= work_bcd_d;
            work_neg_q <= work_neg_d;
            work_ovf_q <= work_ovf_d;
            bcd_out_q  <= bcd_out_d;
            neg_out_q  <= neg_out_d;
            ovf_out_q  <= ovf_out_d;
            done_q     <= done_d;
        end
    end

    assign bus.bcd_out  = bcd_out_q;
    assign bus.negative = neg_out_q;
    assign bus.overflow = ovf_out_q;
    assign bus.done     = done_q;
    assign bus.busy     = (state_q != IDLE);

endmodule

`default_nettype wire

// File: doc/bcd_scaler_mc.md
BCD_SCALER_MC -- requirements
Module: bcd_scaler_mc

Interface
REQ-001 Parameter DATA_W, default 10: width of each signed two's-complement sample.
REQ-002 Parameter NUM_CH, default 3: number of channels converted per request.
REQ-003 Parameter NUM_DIGITS, default 4: BCD digits produced per channel.
REQ-004 Parameter SCALE_SHIFT, default 2: magnitude left-shift before conversion (x4 = mg/LSB).
REQ-005 clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 Load  input  1  conversion request, sampled only in IDLE.
REQ-008 data_in  input  NUM_CH*DATA_W  channel c at bits [c*DATA_W +: DATA_W].
REQ-009 bcd_out  output  NUM_CH*4*NUM_DIGITS  channel c digits at [c*4*NUM_DIGITS +: 4*NUM_DIGITS], ones digit lowest.
REQ-010 negative  output  NUM_CH  sign of each converted sample.
REQ-011 overflow  output  NUM_CH  scaled magnitude exceeded 10^NUM_DIGITS-1.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse; results valid.

Function
REQ-014 The FSM SHALL use states IDLE, LOAD_CH, SHIFT, STORE, DONE.
REQ-015 IDLE with Load=1 SHALL capture data_in into a snapshot register, clear the channel index and enter LOAD_CH.
REQ-016 LOAD_CH SHALL form mag = sign ? -x : x, widen it to W = DATA_W+SCALE_SHIFT bits, shift left by SCALE_SHIFT, clear the digit accumulator, load a bit counter with W-1, and enter SHIFT.
REQ-017 The most-negative input SHALL produce magnitude 2^(DATA_W-1) without wrapping.
REQ-018 SHIFT SHALL process one bit per cycle, MSB first, using double-dabble: add 3 to every digit >=5, then shift left one bit with the next magnitude bit entering ones[0]. It SHALL stay in SHIFT for exactly W cycles, then enter STORE.
REQ-019 STORE SHALL write the digits, the sign and the overflow flag into per-channel working registers. It SHALL then enter LOAD_CH for the next channel, or DONE after channel NUM_CH-1.
REQ-020 DONE SHALL copy all working registers to bcd_out, negative and overflow in the same edge, assert done for that cycle only, and return to IDLE.
REQ-021 The outputs SHALL hold their previous values throughout a conversion and change only as a group in DONE.
REQ-022 Latency: done SHALL be high in cycle NUM_CH*(W+2)+1 after the edge that sampled Load. With defaults this is cycle 43.
REQ-023 Load while busy=1 SHALL be ignored; no queueing.
REQ-024 Load held high SHALL restart a conversion from IDLE on the cycle after done.
REQ-025 data_in changes after the capture edge SHALL NOT affect the results.
REQ-026 overflow[c] SHALL be computed from the full W-bit scaled magnitude, not from the truncated digits.

Reset
REQ-027 rst_n=0 SHALL, asynchronously, set the state to IDLE, clear all counters and the snapshot, and drive bcd_out, negative, overflow, busy and done to 0.
REQ-028 Reset asserted mid-conversion SHALL abort the conversion with no done pulse. The first Load after release SHALL start a fresh conversion.

Configuration
REQ-029 Macro BCD_SATURATE_EN defined: a channel with overflow=1 SHALL report every digit as 4'd9; its overflow flag SHALL still be set.
REQ-030 Macro BCD_SATURATE_EN undefined: an overflowing channel SHALL report the low NUM_DIGITS decimal digits of the scaled magnitude (modulo 10^NUM_DIGITS); its overflow flag SHALL still be set.

Verification
REQ-031 Defaults, ch0=10'd3, ch1=10'h3FF, ch2=10'h200, one-cycle Load -> done at cycle 43 with ch0=0012 neg0, ch1=0004 neg1, ch2=2048 neg1, overflow=000.
REQ-032 Defaults, ch0=10'h1FF, ch1=0, ch2=10'h001; Load pulsed at cycle 10 of a conversion -> no effect, single done pulse, results 2044/0000/0004, busy low after done.
REQ-033 DATA_W=16, NUM_CH=1, data 16'h7FFF (scaled 131068) -> BCD_SATURATE_EN: 9999, overflow=1; BCD_SATURATE_EN undefined: 1068, overflow=1.
REQ-034 rst_n pulsed low at cycle 20 of a conversion -> all outputs 0 immediately, no done pulse. The next Load (ch0=10'd5) -> done at cycle 43 with ch0=0020.
REQ-035 Load held high for 100 cycles -> done pulses 44 cycles apart. data_in changed 2 cycles after each capture edge -> each result matches its snapshot.
